// File: rtl/vdp_pkg.sv
// Shared types and constants for the video display pipeline's line-buffer side.
package vdp_pkg;

  localparam int LB_ADDRW     = 7;
  localparam int PIX_PER_WORD = 16;

  typedef logic [7:0]   pixel_t;
  typedef logic [127:0] lb_word_t;

  typedef enum logic [2:0] {
    SF_IDLE   = 3'd0,
    SF_CLEAR  = 3'd1,
    SF_ACCEPT = 3'd2,
    SF_SPAN   = 3'd3,
    SF_DONE   = 3'd4
  } span_filler_state_t;

endpackage

// File: rtl/span_mask_gen.sv
// Per-pixel write-enable mask for one 16-pixel line-buffer word against an
// inclusive [x0, x1] pixel range.
module span_mask_gen
  import vdp_pkg::*;
#(
  parameter int CORDW = 11
) (
  input  logic [LB_ADDRW-1:0]     word,
  input  logic [CORDW-1:0]        x0,
  input  logic [CORDW-1:0]        x1,
  output logic [PIX_PER_WORD-1:0] mask
);

  logic [31:0] px;

  always_comb begin
    mask = '0;
    px   = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      px      = 32'(word) * 32'(PIX_PER_WORD) + 32'(i);
      mask[i] = (px >= 32'(x0)) && (px <= 32'(x1));
    end
  end

endmodule

// File: rtl/span_filler.sv
// Clears the off-screen line buffer to a background colour on each line_start,
// then rasterises incoming horizontal spans into masked 16-pixel word writes.
module span_filler
  import vdp_pkg::*;
#(
  parameter int CORDW    = 11,
  parameter int LB_WORDS = 80
) (
  input  logic                clk_draw,
  input  logic                rst_draw,
  input  logic                line_start,
  input  logic [7:0]          bg_colour,
  input  logic                span_valid,
  output logic                span_ready,
  input  logic [CORDW-1:0]    span_x0,
  input  logic [CORDW-1:0]    span_x1,
  input  logic [7:0]          span_colour,
  input  logic                span_last,
  output logic [LB_ADDRW-1:0] addr_off_draw,
  output logic [15:0]         we_off_draw,
  output logic [127:0]        colour_off_draw,
  output logic                busy,
  output logic                line_done
);

  localparam int unsigned        LINE_PIX  = LB_WORDS * PIX_PER_WORD;
  localparam logic [CORDW-1:0]   MAX_X     = CORDW'(LINE_PIX - 1);
  localparam logic [LB_ADDRW-1:0] LAST_WORD = LB_ADDRW'(LB_WORDS - 1);

  span_filler_state_t state_q, state_d;
  logic [LB_ADDRW-1:0] cnt_q, cnt_d;
  logic [LB_ADDRW-1:0] word_q, word_d;
  pixel_t              bg_q, bg_d;
  pixel_t              col_q, col_d;
  logic [CORDW-1:0]    x0_q, x0_d;
  logic [CORDW-1:0]    x1_q, x1_d;
  logic                last_q, last_d;
  logic [LB_ADDRW-1:0] addr_q, addr_d;
  logic [15:0]         we_q, we_d;
  lb_word_t            colour_q, colour_d;

  logic                accepting;
  logic [CORDW-1:0]    x1_clamp;
  logic                span_legal;
  logic [LB_ADDRW-1:0] x0_word;
  logic [LB_ADDRW-1:0] x1_word;
  logic [LB_ADDRW-1:0] mask_word;
  logic [CORDW-1:0]    mask_x0;
  logic [CORDW-1:0]    mask_x1;
  logic [15:0]         mask;

  assign accepting  = (state_q == SF_ACCEPT);
  assign span_ready = accepting && !line_start;
  assign busy       = (state_q == SF_CLEAR) || (state_q == SF_SPAN);
  assign line_done  = (state_q == SF_DONE);

  assign x1_clamp   = (span_x1 > MAX_X) ? MAX_X : span_x1;
  assign span_legal = (span_x0 <= span_x1) && (32'(span_x0) < LINE_PIX);
  assign x0_word    = LB_ADDRW'(span_x0 >> 4);
  assign x1_word    = LB_ADDRW'(x1_q >> 4);

  // The write being registered this cycle is the span's first word on a
  // handshake, otherwise the word after the one currently presented.
  assign mask_word = accepting ? x0_word  : word_q + 1'b1;
  assign mask_x0   = accepting ? span_x0  : x0_q;
  assign mask_x1   = accepting ? x1_clamp : x1_q;

  span_mask_gen #(.CORDW(CORDW)) u_mask (
    .word (mask_word),
    .x0   (mask_x0),
    .x1   (mask_x1),
    .mask (mask)
  );

  // cnt_q / word_q hold the index of the word currently on the write port,
  // so the final write is followed by exactly one cycle before the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    bg_d     = bg_q;
    col_d    = col_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    last_d   = last_q;
    addr_d   = addr_q;
    we_d     = '0;
    colour_d = colour_q;

    if (line_start) begin
      state_d  = SF_CLEAR;
      bg_d     = bg_colour;
      cnt_d    = '0;
      addr_d   = '0;
      we_d     = '1;
      colour_d = {16{bg_colour}};
    end else begin
      case (state_q)
        SF_CLEAR: begin
          if (cnt_q == LAST_WORD) begin
            state_d = SF_ACCEPT;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            addr_d   = cnt_q + 1'b1;
            we_d     = '1;
            colour_d = {16{bg_q}};
          end
        end
        SF_ACCEPT: begin
          if (span_valid) begin
            if (!span_legal) begin
              if (span_last) state_d = SF_DONE;
            end else begin
              state_d  = SF_SPAN;
              x0_d     = span_x0;
              x1_d     = x1_clamp;
              col_d    = span_colour;
              last_d   = span_last;
              word_d   = x0_word;
              addr_d   = x0_word;
              we_d     = mask;
              colour_d = {16{span_colour}};
            end
          end
        end
        SF_SPAN: begin
          if (word_q == x1_word) begin
            state_d = last_q ? SF_DONE : SF_ACCEPT;
          end else begin
            word_d   = word_q + 1'b1;
            addr_d   = word_q + 1'b1;
            we_d     = mask;
            colour_d = {16{col_q}};
          end
        end
        SF_DONE: state_d = SF_IDLE;
        default: state_d = SF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_q  <= SF_IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      bg_q     <= '0;
      col_q    <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      last_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      bg_q     <= bg_d;
      col_q    <= col_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      colour_q <= colour_d;
    end
  end

  assign addr_off_draw   = addr_q;
  assign we_off_draw     = we_q;
  assign colour_off_draw = colour_q;

endmodule
